// File: rtl/ahb2apb_pkg.sv
// Shared types and constants for the AHB-lite to APB bridge.
//   htrans_e       : AHB HTRANS encodings
//   bridge_state_e : bridge FSM states
//   HRESP_OKAY / HRESP_ERROR : AHB response codes
//   DATA_W         : AHB/APB data width
package ahb2apb_pkg;

  localparam int unsigned DATA_W = 32;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [1:0] {
    TRANS_IDLE   = 2'b00,
    TRANS_BUSY   = 2'b01,
    TRANS_NONSEQ = 2'b10,
    TRANS_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [2:0] {
    IDLE,
    WDATA,
    SETUP,
    ACCESS,
    ERR1,
    ERR2
  } bridge_state_e;

endpackage

// File: rtl/ahb2apb_bridge_core_apb_slave_mux.sv
// Return-path multiplexer: picks the PRDATA/PREADY/PSLVERR of the slave
// addressed by sel_idx. Purely combinational.
//   sel_idx  in  IDX_W               slave index of the current transfer
//   prdata   in  DATA_W*NO_OF_SLAVES per-slave read data, slave i at [DATA_W*i +: DATA_W]
//   pready   in  NO_OF_SLAVES        per-slave ready
//   pslverr  in  NO_OF_SLAVES        per-slave error
//   rdata    out DATA_W              selected read data
//   ready    out 1                   selected ready
//   slverr   out 1                   selected error
module apb_slave_mux
  import ahb2apb_pkg::*;
#(
  parameter int unsigned NO_OF_SLAVES = 8,
  parameter int unsigned IDX_W        = 3
) (
  input  logic [IDX_W-1:0]               sel_idx,
  input  logic [DATA_W*NO_OF_SLAVES-1:0] prdata,
  input  logic [NO_OF_SLAVES-1:0]        pready,
  input  logic [NO_OF_SLAVES-1:0]        pslverr,
  output logic [DATA_W-1:0]              rdata,
  output logic                           ready,
  output logic                           slverr
);

  always_comb begin
    rdata  = '0;
    ready  = 1'b0;
    slverr = 1'b0;
    for (int unsigned i = 0; i < NO_OF_SLAVES; i++) begin
      if (sel_idx == IDX_W'(i)) begin
        rdata  = prdata[DATA_W*i +: DATA_W];
        ready  = pready[i];
        slverr = pslverr[i];
      end
    end
  end

endmodule

// File: rtl/ahb2apb_bridge_core.sv
// AHB-lite slave to APB master bridge, one transfer at a time.
//   HCLK/HRESETn          clock, asynchronous active-low reset
//   HSELAHB, HADDR, HTRANS, HWRITE, HWDATA   AHB request
//   HRDATA, HREADY, HRESP AHB response
//   PADDR, PSELx, PENABLE, PWRITE, PWDATA    APB request (one-hot PSELx)
//   PRDATA, PREADY, PSLVERR                  per-slave APB return
module ahb2apb_bridge_core
  import ahb2apb_pkg::*;
#(
  parameter int unsigned NO_OF_SLAVES = 8,
  parameter int unsigned SLV_IDX_LSB  = 24
) (
  input  logic                           HCLK,
  input  logic                           HRESETn,
  input  logic                           HSELAHB,
  input  logic [31:0]                    HADDR,
  input  logic [1:0]                     HTRANS,
  input  logic                           HWRITE,
  input  logic [DATA_W-1:0]              HWDATA,
  output logic [DATA_W-1:0]              HRDATA,
  output logic                           HREADY,
  output logic                           HRESP,
  output logic [31:0]                    PADDR,
  output logic [NO_OF_SLAVES-1:0]        PSELx,
  output logic                           PENABLE,
  output logic                           PWRITE,
  output logic [DATA_W-1:0]              PWDATA,
  input  logic [DATA_W*NO_OF_SLAVES-1:0] PRDATA,
  input  logic [NO_OF_SLAVES-1:0]        PREADY,
  input  logic [NO_OF_SLAVES-1:0]        PSLVERR
);

  localparam int unsigned IDX_W = (NO_OF_SLAVES > 1) ? $clog2(NO_OF_SLAVES) : 1;

  bridge_state_e       state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [31:0]         paddr_q, paddr_d;
  logic                pwrite_q, pwrite_d;
  logic [DATA_W-1:0]   pwdata_q, pwdata_d;
  logic [DATA_W-1:0]   hrdata_q, hrdata_d;

  logic [IDX_W-1:0]    haddr_idx;
  logic [2**IDX_W-1:0] slot_present;
  logic                req_valid;
  logic [DATA_W-1:0]   sel_rdata;
  logic                sel_ready;
  logic                sel_slverr;

  assign haddr_idx = HADDR[SLV_IDX_LSB +: IDX_W];
  assign req_valid = HSELAHB &&
                     (htrans_e'(HTRANS) == TRANS_NONSEQ || htrans_e'(HTRANS) == TRANS_SEQ);

  // Index field can encode more slots than exist; mark the populated ones.
  always_comb begin
    slot_present = '0;
    for (int unsigned i = 0; i < NO_OF_SLAVES; i++) slot_present[i] = 1'b1;
  end

  apb_slave_mux #(
    .NO_OF_SLAVES(NO_OF_SLAVES),
    .IDX_W       (IDX_W)
  ) u_mux (
    .sel_idx(idx_q),
    .prdata (PRDATA),
    .pready (PREADY),
    .pslverr(PSLVERR),
    .rdata  (sel_rdata),
    .ready  (sel_ready),
    .slverr (sel_slverr)
  );

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      paddr_q  <= '0;
      pwrite_q <= 1'b0;
      pwdata_q <= '0;
      hrdata_q <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      paddr_q  <= paddr_d;
      pwrite_q <= pwrite_d;
      pwdata_q <= pwdata_d;
      hrdata_q <= hrdata_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    paddr_d  = paddr_q;
    pwrite_d = pwrite_q;
    pwdata_d = pwdata_q;
    hrdata_d = hrdata_q;
    case (state_q)
      // ERR2 is a response cycle with HREADY=1, so it accepts requests like IDLE.
      IDLE, ERR2: begin
        state_d = IDLE;
        if (req_valid) begin
          if (!slot_present[haddr_idx]) begin
            state_d = ERR1;
          end else begin
            paddr_d  = HADDR;
            pwrite_d = HWRITE;
            idx_d    = haddr_idx;
            state_d  = HWRITE ? WDATA : SETUP;
          end
        end
      end
      WDATA: begin
        pwdata_d = HWDATA;
        state_d  = SETUP;
      end
      SETUP:  state_d = ACCESS;
      ACCESS: begin
        if (sel_ready) begin
          if (sel_slverr) begin
            state_d = ERR1;
          end else begin
            if (!pwrite_q) hrdata_d = sel_rdata;
            state_d = IDLE;
          end
        end
      end
      ERR1:    state_d = ERR2;
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs decode straight from the state register so that an
  // asynchronous reset drops PSELx/PENABLE without waiting for a clock.
  always_comb begin
    HREADY  = (state_q == IDLE) || (state_q == ERR2);
    HRESP   = ((state_q == ERR1) || (state_q == ERR2)) ? HRESP_ERROR : HRESP_OKAY;
    PENABLE = (state_q == ACCESS);
    PSELx   = '0;
    if (state_q == SETUP || state_q == ACCESS) begin
      for (int unsigned i = 0; i < NO_OF_SLAVES; i++) PSELx[i] = (idx_q == IDX_W'(i));
    end
  end

  assign HRDATA = hrdata_q;
  assign PADDR  = paddr_q;
  assign PWRITE = pwrite_q;
  assign PWDATA = pwdata_q;

endmodule

// File: tb/tb_ahb2apb_bridge_core.sv
// Directed self-checking bench for ahb2apb_bridge_core (8 slaves, index at HADDR[26:24]).
module tb_ahb2apb_bridge_core;

  logic          HCLK = 1'b0;
  logic          HRESETn;
  logic          HSELAHB;
  logic [31:0]   HADDR;
  logic [1:0]    HTRANS;
  logic          HWRITE;
  logic [31:0]   HWDATA;
  logic [31:0]   HRDATA;
  logic          HREADY;
  logic          HRESP;
  logic [31:0]   PADDR;
  logic [7:0]    PSELx;
  logic          PENABLE;
  logic          PWRITE;
  logic [31:0]   PWDATA;
  logic [255:0]  PRDATA;
  logic [7:0]    PREADY;
  logic [7:0]    PSLVERR;

  int unsigned checks = 0;
  int unsigned errors = 0;

  ahb2apb_bridge_core #(
    .NO_OF_SLAVES(8),
    .SLV_IDX_LSB (24)
  ) dut (
    .HCLK   (HCLK),
    .HRESETn(HRESETn),
    .HSELAHB(HSELAHB),
    .HADDR  (HADDR),
    .HTRANS (HTRANS),
    .HWRITE (HWRITE),
    .HWDATA (HWDATA),
    .HRDATA (HRDATA),
    .HREADY (HREADY),
    .HRESP  (HRESP),
    .PADDR  (PADDR),
    .PSELx  (PSELx),
    .PENABLE(PENABLE),
    .PWRITE (PWRITE),
    .PWDATA (PWDATA),
    .PRDATA (PRDATA),
    .PREADY (PREADY),
    .PSLVERR(PSLVERR)
  );

  always #5 HCLK = ~HCLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs set afterwards are
  // sampled on the following edge.
  task automatic step();
    @(posedge HCLK);
    #1;
  endtask

  task automatic ahb_idle();
    HSELAHB = 1'b0;
    HTRANS  = 2'b00;
    HWRITE  = 1'b0;
    HADDR   = 32'h0;
  endtask

  task automatic ahb_req(input logic [31:0] addr, input logic wr, input logic [1:0] trans);
    HSELAHB = 1'b1;
    HTRANS  = trans;
    HWRITE  = wr;
    HADDR   = addr;
  endtask

  initial begin
    HRESETn = 1'b0;
    ahb_idle();
    HWDATA  = 32'h0;
    PREADY  = 8'hFF;
    PSLVERR = 8'h00;
    for (int i = 0; i < 8; i++) PRDATA[32*i +: 32] = 32'h1111_1111 * i;

    // ---------------- reset state ----------------
    step();
    step();
    chk("rst_hready", {31'b0, HREADY}, 32'd1);
    chk("rst_hresp", {31'b0, HRESP}, 32'd0);
    chk("rst_hrdata", HRDATA, 32'h0);
    chk("rst_psel", {24'b0, PSELx}, 32'h0);
    chk("rst_penable", {31'b0, PENABLE}, 32'd0);
    chk("rst_paddr", PADDR, 32'h0);
    chk("rst_pwdata", PWDATA, 32'h0);
    chk("rst_pwrite", {31'b0, PWRITE}, 32'd0);
    HRESETn = 1'b1;
    step();

    // ---------------- read, zero wait, slave 2 ----------------
    PRDATA[32*2 +: 32] = 32'hDEAD_BEEF;
    PRDATA[32*3 +: 32] = 32'h5555_AAAA;
    ahb_req(32'h0200_0010, 1'b0, 2'b10);
    chk("rd_addr_phase_hready", {31'b0, HREADY}, 32'd1);
    step(); // T+1 SETUP
    ahb_idle();
    chk("rd_setup_psel", {24'b0, PSELx}, 32'h04);
    chk("rd_setup_penable", {31'b0, PENABLE}, 32'd0);
    chk("rd_setup_paddr", PADDR, 32'h0200_0010);
    chk("rd_setup_pwrite", {31'b0, PWRITE}, 32'd0);
    chk("rd_setup_hready", {31'b0, HREADY}, 32'd0);
    step(); // T+2 ACCESS
    chk("rd_access_psel", {24'b0, PSELx}, 32'h04);
    chk("rd_access_penable", {31'b0, PENABLE}, 32'd1);
    chk("rd_access_hready", {31'b0, HREADY}, 32'd0);
    step(); // T+3 response
    chk("rd_resp_hready", {31'b0, HREADY}, 32'd1);
    chk("rd_resp_hresp", {31'b0, HRESP}, 32'd0);
    chk("rd_resp_hrdata", HRDATA, 32'hDEAD_BEEF);
    chk("rd_resp_psel", {24'b0, PSELx}, 32'h0);

    // ---------------- write, 3 wait states, slave 5 ----------------
    PREADY     = 8'hFF;
    PREADY[5]  = 1'b0;
    PSLVERR[4] = 1'b1;   // unselected slave error must be ignored
    ahb_req(32'h0500_0004, 1'b1, 2'b10);
    step(); // T+1 WDATA
    ahb_idle();
    HWDATA = 32'h1234_5678;
    chk("wr_wdata_hready", {31'b0, HREADY}, 32'd0);
    chk("wr_wdata_psel", {24'b0, PSELx}, 32'h0);
    step(); // T+2 SETUP
    HWDATA = 32'hFFFF_0000;
    chk("wr_setup_psel", {24'b0, PSELx}, 32'h20);
    chk("wr_setup_penable", {31'b0, PENABLE}, 32'd0);
    chk("wr_setup_pwdata", PWDATA, 32'h1234_5678);
    chk("wr_setup_pwrite", {31'b0, PWRITE}, 32'd1);
    chk("wr_setup_paddr", PADDR, 32'h0500_0004);
    for (int w = 0; w < 4; w++) begin
      step(); // T+3..T+6 ACCESS
      if (w == 3) PREADY[5] = 1'b1;
      chk("wr_access_psel", {24'b0, PSELx}, 32'h20);
      chk("wr_access_penable", {31'b0, PENABLE}, 32'd1);
      chk("wr_access_pwdata", PWDATA, 32'h1234_5678);
      chk("wr_access_paddr", PADDR, 32'h0500_0004);
      chk("wr_access_hready", {31'b0, HREADY}, 32'd0);
    end
    step(); // T+7 response
    chk("wr_resp_hready", {31'b0, HREADY}, 32'd1);
    chk("wr_resp_hresp", {31'b0, HRESP}, 32'd0);
    chk("wr_resp_hrdata_kept", HRDATA, 32'hDEAD_BEEF);
    chk("wr_resp_psel", {24'b0, PSELx}, 32'h0);
    PSLVERR = 8'h00;

    // ---------------- slave error, read slave 7 ----------------
    PRDATA[32*7 +: 32] = 32'hBAD0_BAD0;
    PSLVERR[7] = 1'b1;
    ahb_req(32'h0700_0000, 1'b0, 2'b10);
    step(); // SETUP
    ahb_idle();
    chk("err_setup_psel", {24'b0, PSELx}, 32'h80);
    step(); // ACCESS
    chk("err_access_penable", {31'b0, PENABLE}, 32'd1);
    step(); // ERR1
    chk("err1_hready", {31'b0, HREADY}, 32'd0);
    chk("err1_hresp", {31'b0, HRESP}, 32'd1);
    chk("err1_psel", {24'b0, PSELx}, 32'h0);
    chk("err1_penable", {31'b0, PENABLE}, 32'd0);
    step(); // ERR2
    chk("err2_hready", {31'b0, HREADY}, 32'd1);
    chk("err2_hresp", {31'b0, HRESP}, 32'd1);
    chk("err2_hrdata_kept", HRDATA, 32'hDEAD_BEEF);
    step(); // back to IDLE
    chk("err_after_hresp", {31'b0, HRESP}, 32'd0);
    chk("err_after_hready", {31'b0, HREADY}, 32'd1);
    PSLVERR = 8'h00;

    // ---------------- back-to-back: write slave 0, read slave 1 ----------------
    PRDATA[32*1 +: 32] = 32'hCAFE_F00D;
    ahb_req(32'h0000_0008, 1'b1, 2'b10);
    step(); // WDATA
    ahb_idle();
    HWDATA = 32'hA5A5_0001;
    step(); // SETUP
    chk("b2b_wr_setup_psel", {24'b0, PSELx}, 32'h01);
    step(); // ACCESS
    chk("b2b_wr_access_psel", {24'b0, PSELx}, 32'h01);
    chk("b2b_wr_access_pwdata", PWDATA, 32'hA5A5_0001);
    step(); // write response cycle: present the read here
    chk("b2b_wr_resp_hready", {31'b0, HREADY}, 32'd1);
    chk("b2b_gap_psel", {24'b0, PSELx}, 32'h0);
    ahb_req(32'h0100_000C, 1'b0, 2'b10);
    step(); // read SETUP straight away
    ahb_idle();
    chk("b2b_rd_setup_psel", {24'b0, PSELx}, 32'h02);
    chk("b2b_rd_setup_paddr", PADDR, 32'h0100_000C);
    chk("b2b_rd_setup_pwrite", {31'b0, PWRITE}, 32'd0);
    step(); // ACCESS
    chk("b2b_rd_access_penable", {31'b0, PENABLE}, 32'd1);
    step(); // response
    chk("b2b_rd_resp_hready", {31'b0, HREADY}, 32'd1);
    chk("b2b_rd_resp_hrdata", HRDATA, 32'hCAFE_F00D);

    // ---------------- IDLE/BUSY/unselected traffic ----------------
    for (int k = 0; k < 4; k++) begin
      HSELAHB = (k < 2);
      HTRANS  = (k == 0) ? 2'b00 : (k == 1) ? 2'b01 : (k == 2) ? 2'b10 : 2'b11;
      HWRITE  = k[0];
      HADDR   = 32'h0300_0000;
      step();
      chk("noxfer_hready", {31'b0, HREADY}, 32'd1);
      chk("noxfer_psel", {24'b0, PSELx}, 32'h0);
      chk("noxfer_hresp", {31'b0, HRESP}, 32'd0);
    end
    ahb_idle();
    step();

    // ---------------- reset during ACCESS wait ----------------
    PRDATA[32*3 +: 32] = 32'h3333_3333;
    PREADY[3] = 1'b0;
    ahb_req(32'h0300_0000, 1'b0, 2'b10);
    step(); // SETUP
    ahb_idle();
    step(); // ACCESS, waiting
    chk("rst_mid_access_psel", {24'b0, PSELx}, 32'h08);
    chk("rst_mid_access_penable", {31'b0, PENABLE}, 32'd1);
    #2;
    HRESETn = 1'b0;
    #1;
    chk("rst_mid_psel", {24'b0, PSELx}, 32'h0);
    chk("rst_mid_penable", {31'b0, PENABLE}, 32'd0);
    chk("rst_mid_hready", {31'b0, HREADY}, 32'd1);
    chk("rst_mid_hrdata", HRDATA, 32'h0);
    step();
    HRESETn = 1'b1;
    PREADY  = 8'hFF;
    step();
    chk("post_rst_psel", {24'b0, PSELx}, 32'h0);
    ahb_req(32'h0300_0020, 1'b0, 2'b11);
    step();
    ahb_idle();
    chk("post_rst_setup_psel", {24'b0, PSELx}, 32'h08);
    chk("post_rst_setup_paddr", PADDR, 32'h0300_0020);
    step();
    step();
    chk("post_rst_hready", {31'b0, HREADY}, 32'd1);
    chk("post_rst_hrdata", HRDATA, 32'h3333_3333);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ahb2apb_bridge_core.md
Name: ahb2apb_bridge_core

Overview:
Single-clock AHB-lite slave to APB master bridge, the initiator side of the APB slave bus driven by the bench's APB driver. It accepts one AHB transfer at a time, decodes the target APB slave from HADDR, runs the APB SETUP/ACCESS sequence and returns read data or an error response to AHB. Multi-slave fan-out uses one-hot PSELx with per-slave PRDATA/PREADY/PSLVERR return.

Parameters:
NO_OF_SLAVES, 8, number of APB slaves (1..8)
SLV_IDX_LSB, 24, LSB of the slave-index field in HADDR (field width $clog2(NO_OF_SLAVES), minimum 1)

Ports:
HCLK  in  1  bridge clock (AHB and APB share it)
HRESETn  in  1  asynchronous active-low reset
HSELAHB  in  1  bridge select
HADDR  in  32  AHB address
HTRANS  in  2  AHB transfer type
HWRITE  in  1  1=write
HWDATA  in  32  write data (data phase)
HRDATA  out  32  read data
HREADY  out  1  transfer done / bridge ready
HRESP  out  1  0=OKAY, 1=ERROR
PADDR  out  32  APB address
PSELx  out  NO_OF_SLAVES  one-hot slave select
PENABLE  out  1  APB access phase
PWRITE  out  1  APB direction
PWDATA  out  32  APB write data
PRDATA  in  32*NO_OF_SLAVES  per-slave read data, slave i at [32*i+:32]
PREADY  in  NO_OF_SLAVES  per-slave ready
PSLVERR  in  NO_OF_SLAVES  per-slave error

Behaviour:
- One clock, HCLK; reset HRESETn is asynchronous, active-low. All state registers clear immediately on HRESETn low.
- Reset values: HREADY=1, HRESP=0, HRDATA=0, PSELx=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, state=IDLE.
- Reset mid-transfer: PSELx and PENABLE drop asynchronously. No completion is signalled.
- Valid transfer = HSELAHB & HTRANS[1] (NONSEQ/SEQ) sampled while HREADY=1.
- IDLE/BUSY or unselected: HREADY stays 1, HRESP=0, and the bridge stays in IDLE.
- FSM states: IDLE, WDATA, SETUP, ACCESS, ERR1, ERR2.
- IDLE, on a valid transfer: latch HADDR, HWRITE and the slave index. Write goes to WDATA; read goes to SETUP.
- IDLE, invalid slave index (index >= NO_OF_SLAVES): go to ERR1; no APB activity.
- WDATA: HREADY=0; latch HWDATA into PWDATA; go to SETUP.
- SETUP: HREADY=0; PSELx[idx]=1, PENABLE=0, PADDR and PWRITE valid; go to ACCESS.
- ACCESS: HREADY=0; PENABLE=1.
  - PREADY[idx]=0: stay in ACCESS. Wait states are unbounded.
  - PREADY[idx]=1 and PSLVERR[idx]=0: go to IDLE. On a read, capture PRDATA[idx] into HRDATA. The IDLE cycle carries HREADY=1, HRESP=0 and completes the transfer.
  - PREADY[idx]=1 and PSLVERR[idx]=1: go to ERR1. HRDATA is not updated.
- ERR1: HREADY=0, HRESP=1, PSELx=0.
- ERR2: HREADY=1, HRESP=1. A new valid transfer is accepted here with the same rules as IDLE; otherwise go to IDLE.
- PADDR, PWRITE, PWDATA and PSELx are stable from SETUP through the last ACCESS cycle. PSELx=0 and PENABLE=0 in all other states.
- HRDATA holds the last successful read value; writes and errors leave it unchanged.
- Latency with zero wait states:
  - Read: address phase T; response (HREADY=1) at T+3.
  - Write: response at T+4.
  - Each PREADY-low cycle adds 1.
- Back-to-back: an address phase presented in the response cycle (HREADY=1) is accepted, giving no idle bubble on the AHB side.
- The PREADY, PSLVERR and PRDATA of unselected slaves are ignored.

Decomposition:
- Package ahb2apb_pkg holds:
  - htrans_e (IDLE=2'b00, BUSY=2'b01, NONSEQ=2'b10, SEQ=2'b11)
  - bridge_state_e
  - HRESP_OKAY and HRESP_ERROR constants
  - the DATA_W=32 constant
- One sub-module, apb_slave_mux: combinational selection of PRDATA, PREADY and PSLVERR by slave index.

Test Plan:
- Read, zero wait: HADDR=0x0200_0010, NONSEQ, HWRITE=0; slave 2 returns PREADY=1, PRDATA=0xDEAD_BEEF -> PSELx=8'h04 for 2 cycles, PENABLE only in the second; HRDATA=0xDEAD_BEEF with HREADY=1 at T+3.
- Write with 3 wait states: HADDR=0x0500_0004, HWDATA=0x1234_5678; slave 5 holds PREADY low 3 cycles -> PWDATA=0x1234_5678 stable throughout; PSELx=8'h20; HREADY=1 at T+7.
- Slave error: read of slave 7 with PSLVERR=1 -> two-cycle ERROR response: HREADY=0/HRESP=1, then HREADY=1/HRESP=1; HRDATA unchanged.
- Back-to-back: a write to slave 0 and a new NONSEQ read to slave 1 issued in the write's response cycle -> read accepted immediately; PSELx goes 8'h01 then 8'h02 with exactly 1 idle APB cycle between.
- IDLE/BUSY and HSELAHB=0 traffic -> HREADY stays 1, PSELx stays 0.
- HRESETn asserted while in ACCESS with PREADY low -> PSELx=0, PENABLE=0, HREADY=1 in the same cycle; a subsequent read completes normally.
